// File: rtl/adder_rr_arbiter_if.sv
// Handshake bundle for adder_rr_arbiter: per-requester operand ports and the
// shared result port. The res_carry wire exists only when ADDER_ARB_CARRY_EN
// is defined.
interface adder_rr_arbiter_if #(
  parameter int WIDTH   = 64,
  parameter int NUM_REQ = 2,
  localparam int IDW    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     res_valid;
  logic [WIDTH-1:0]         res_data;
  logic [IDW-1:0]           res_id;
  logic                     res_ready;
`ifdef ADDER_ARB_CARRY_EN
  logic                     res_carry;
`endif

  // Requesters and result consumer side
  modport master (
`ifdef ADDER_ARB_CARRY_EN
    input  res_carry,
`endif
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  // Arbiter side
  modport slave (
`ifdef ADDER_ARB_CARRY_EN
    output res_carry,
`endif
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: one WIDTH-bit adder shared by NUM_REQ requesters.
// Round-robin grant is combinational; the sum lands in a single output
// register tagged with the owning requester ID. A full slot accepts a new
// request in the same cycle it drains, so throughput is one add per cycle.
// Optional feature: define ADDER_ARB_CARRY_EN to expose the registered
// carry-out on res_carry.
module adder_rr_arbiter #(
  parameter int WIDTH   = 64,
  parameter int NUM_REQ = 2,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_rr_arbiter_if.slave bus
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  // Full-width add; the top bit is the carry-out.
  function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
`ifdef ADDER_ARB_CARRY_EN
  logic             carry_q, carry_d;
`endif

  logic [WIDTH-1:0]   a_arr [NUM_REQ];
  logic [WIDTH-1:0]   b_arr [NUM_REQ];
  logic               found;
  logic [IDW-1:0]     win;
  logic [IDW-1:0]     idx;
  logic               slot_free;
  logic               accept;
  logic [NUM_REQ-1:0] ready_c;
  logic [WIDTH:0]     sum_full;

  // Unpack the flat operand buses so the winner can be picked by index.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = bus.req_b[g*WIDTH +: WIDTH];
  end

  // A drained-this-cycle slot counts as free, giving back-to-back accepts.
  assign slot_free = (state_q == S_EMPTY) | bus.res_ready;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // One-hot ready to the winner only; held low throughout reset.
  always_comb begin
    ready_c = '0;
    if (found && slot_free && rst_n) begin
      ready_c[win] = 1'b1;
    end
  end

  assign accept        = found & slot_free & rst_n;
  assign bus.req_ready = ready_c;
  assign sum_full      = add_carry(a_arr[win], b_arr[win]);

  // Slot FSM, result capture and round-robin pointer advance.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    id_d     = id_q;
`ifdef ADDER_ARB_CARRY_EN
    carry_d  = carry_q;
`endif
    if (accept) begin
      state_d = S_FULL;
      data_d  = sum_full[WIDTH-1:0];
      id_d    = win;
`ifdef ADDER_ARB_CARRY_EN
      carry_d = sum_full[WIDTH];
`endif
      if (win == IDW'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win + IDW'(1);
      end
    end else if ((state_q == S_FULL) && bus.res_ready) begin
      state_d = S_EMPTY;
    end
  end

`ifndef ADDER_ARB_CARRY_EN
  logic unused_carry;
  assign unused_carry = sum_full[WIDTH];
`endif

  // ---- output register stage ----
  // Asynchronous reset clears the pending result and the arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_EMPTY;
      rr_ptr_q <= '0;
      data_q   <= '0;
      id_q     <= '0;
`ifdef ADDER_ARB_CARRY_EN
      carry_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      id_q     <= id_d;
`ifdef ADDER_ARB_CARRY_EN
      carry_q  <= carry_d;
`endif
    end
  end

  assign bus.res_valid = (state_q == S_FULL);
  assign bus.res_data  = data_q;
  assign bus.res_id    = id_q;
`ifdef ADDER_ARB_CARRY_EN
  assign bus.res_carry = carry_q;
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Bench for adder_rr_arbiter (WIDTH=64, NUM_REQ=2). Accepted requests push
// their hand-computed sum into a scoreboard queue; a monitor pops and
// compares whenever a result is handed over on the result port.
module tb_adder_rr_arbiter;
  localparam int W   = 64;
  localparam int N   = 2;
  localparam int IDW = $clog2(N);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
    logic           carry;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  exp_t         sb[$];
  logic [W-1:0] exp_sum   [N];
  logic         exp_carry [N];

  logic [1:0]   fair_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [W-1:0] wa [4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
                           64'h8000_0000_0000_0000, 64'h0000_0001_0000_0000};
  logic [W-1:0] wb [4] = '{64'h1, 64'h1, 64'h8000_0000_0000_0000,
                           64'h0000_0000_FFFF_FFFF};
  logic [W-1:0] ws [4] = '{64'h0, 64'h0000_0001_0000_0000, 64'h0,
                           64'h0000_0001_FFFF_FFFF};
  logic         wc [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  adder_rr_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

  adder_rr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] s, input logic c);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    exp_sum[i]   = s;
    exp_carry[i] = c;
  endtask

  // Record every handshake seen on the request side.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb.push_back('{id: IDW'(i), data: exp_sum[i], carry: exp_carry[i]});
        end
      end
    end
  end

  // Compare each result as it is handed to the consumer.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(bus.res_data), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("sb_res_data", bus.res_data, e.data);
        chk("sb_res_id", 64'(bus.res_id), 64'(e.id));
`ifdef ADDER_ARB_CARRY_EN
        chk("sb_res_carry", 64'(bus.res_carry), 64'(e.carry));
`endif
      end
    end
  end

  initial begin
    rst_n         = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    #2 rst_n = 1'b0;

    // Reset with both requesters asking
    set_req(0, 64'd1, 64'd2, 64'd3, 1'b0);
    set_req(1, 64'd3, 64'd4, 64'd7, 1'b0);
    bus.req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_data", bus.res_data, 64'd0);
    chk("rst_res_id", 64'(bus.res_id), 64'd0);

    // Release between edges; grants then alternate starting at req 0
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fair_grant", 64'(bus.req_ready), 64'(fair_exp[k]));
    end

    // Single request from req 0
    @(posedge clk); #1 bus.req_valid = 2'b01;
    @(negedge clk);
    chk("single_ready", 64'(bus.req_ready), 64'b01);

    // Backpressure for 3 cycles with req 1 waiting
    @(posedge clk); #1;
    bus.req_valid = 2'b10;
    set_req(1, 64'd5, 64'd6, 64'd11, 1'b0);
    bus.res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_res_valid", 64'(bus.res_valid), 64'd1);
      chk("bp_res_data", bus.res_data, 64'd3);
      chk("bp_res_id", 64'(bus.res_id), 64'd0);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
    end
    @(posedge clk); #1 bus.res_ready = 1'b1;
    @(negedge clk);
    chk("drain_accept_ready", 64'(bus.req_ready), 64'b10);
    @(posedge clk); #1 bus.req_valid = 2'b00;
    @(negedge clk);
    chk("after_drain_valid", 64'(bus.res_valid), 64'd1);
    chk("after_drain_id", 64'(bus.res_id), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_res_valid", 64'(bus.res_valid), 64'd0);

    // Carry / wrap vectors, back to back, alternating requesters
    @(posedge clk); #1;
    for (int v = 0; v < 4; v++) begin
      set_req(v % 2, wa[v], wb[v], ws[v], wc[v]);
      bus.req_valid = (v % 2 == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      chk("wrap_ready", 64'(bus.req_ready), (v % 2 == 1) ? 64'b10 : 64'b01);
      @(posedge clk); #1;
    end

    // Async reset while a result is held
    set_req(0, 64'd1, 64'd2, 64'd3, 1'b0);
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("pre_rst_ready", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1;
    set_req(1, 64'd3, 64'd4, 64'd7, 1'b0);
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_res_valid", 64'(bus.res_valid), 64'd1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("arst_res_data", bus.res_data, 64'd0);
    chk("arst_res_id", 64'(bus.res_id), 64'd0);
    chk("arst_req_ready", 64'(bus.req_ready), 64'd0);
`ifdef ADDER_ARB_CARRY_EN
    chk("arst_res_carry", 64'(bus.res_carry), 64'd0);
`endif
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("arst_ptr_grant", 64'(bus.req_ready), 64'b01);
    @(posedge clk); #1 bus.req_valid = 2'b00;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("final_res_valid", 64'(bus.res_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
